bitslam_sequencer: RTL

- Autonomous register-write sequencer for the bitslam synth core.
- Steps through a small host-loaded program of (register address, data) writes and drives the synth's shared 6-bit two-phase address/data bus:
  - address phase: `sel`=0
  - data phase: `sel`=1
- Optional waits on a programmable tempo tick turn the program into a musical pattern with no host traffic during playback.
- Sits between the host/config pins and the synth core's `io_in[7:1]` inputs.

---
 rtl/bitslam_pkg.sv | 28 ++
 rtl/bitslam_tempo.sv | 42 ++++
 rtl/bitslam_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bitslam_pkg.sv
// Shared types and constants for the bitslam register-write sequencer.
package bitslam_pkg;

  // Synth register addresses
  localparam logic [2:0] VOICE0_DIV = 3'd0;
  localparam logic [2:0] VOICE0_TAP = 3'd1;
  localparam logic [2:0] VOICE1_DIV = 3'd2;
  localparam logic [2:0] VOICE1_TAP = 3'd3;
  localparam logic [2:0] MIXER_VOL  = 3'd4;

  localparam int unsigned ENTRY_W = 10;
  localparam int unsigned BUS_W   = 6;

  // One program step: optional tempo wait, synth register address, data
  typedef struct packed {
    logic        wait_f;
    logic [2:0]  addr;
    logic [5:0]  data;
  } step_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_WAIT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/bitslam_tempo.sv
// Free-running tempo counter with a combinational beat at each wrap.
module bitslam_tempo #(
  parameter int unsigned TEMPO_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               run_i,
  input  logic [TEMPO_W-1:0] tempo_i,
  output logic               beat_o
);

  logic [TEMPO_W-1:0] cnt_q;
  logic [TEMPO_W-1:0] cnt_d;
  logic               wrap;

  // Equality compare only: a tempo lowered below the count rolls over the full range
  assign wrap   = (cnt_q == tempo_i);
  assign beat_o = run_i && wrap;

  // Next count: forced to zero when cleared, otherwise count and wrap at tempo
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TEMPO_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bitslam_sequencer.sv
// Plays a host-loaded list of synth register writes over the two-phase bus.
module bitslam_sequencer
  import bitslam_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TEMPO_W = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [ENTRY_W-1:0]         prog_data,
  input  logic [$clog2(DEPTH)-1:0]   last_step,
  input  logic [TEMPO_W-1:0]         tempo,
  input  logic                       start,
  input  logic                       stop,
  output logic                       bus_sel,
  output logic [BUS_W-1:0]           bus_addr_data,
  output logic                       running,
  output logic [$clog2(DEPTH)-1:0]   step,
  output logic                       beat
);

  localparam int unsigned IW = $clog2(DEPTH);

  step_entry_t table_q [DEPTH];

  seq_state_e  state_q, state_d;
  logic [IW-1:0] pc_q, pc_d, pc_next;
  step_entry_t cur_q, cur_d;
  logic        fetch;

  logic             bus_sel_q, bus_sel_d;
  logic [BUS_W-1:0] bus_ad_q, bus_ad_d;
  logic             running_q, running_d;
  logic [IW-1:0]    step_q, step_d;
  logic             tempo_clear;

  // Program table, host-writable at any time, intentionally not reset
  always_ff @(posedge clk) begin
    if (prog_we) begin
      table_q[prog_addr] <= step_entry_t'(prog_data);
    end
  end

  // Tempo runs only while playing; held at zero in IDLE and on entry
  assign tempo_clear = (state_q == ST_IDLE) || (state_d == ST_IDLE);

  bitslam_tempo #(
    .TEMPO_W (TEMPO_W)
  ) u_tempo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tempo_clear),
    .run_i   (running_q),
    .tempo_i (tempo),
    .beat_o  (beat)
  );

  assign pc_next = (pc_q == last_step) ? '0 : pc_q + IW'(1);

  // Next-state logic; the fetch reads the pre-write table so a colliding write lands next lap
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fetch   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_ADDR;
          pc_d    = '0;
          fetch   = 1'b1;
        end
      end
      ST_ADDR: begin
        state_d = stop ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cur_q.wait_f) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ADDR;
          pc_d    = pc_next;
          fetch   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          state_d = ST_ADDR;
          pc_d    = pc_next;
          fetch   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cur_d = fetch ? table_q[pc_d] : cur_q;
  end

  // Output decode from the next state so bus outputs are registered with it
  always_comb begin
    bus_sel_d = 1'b0;
    bus_ad_d  = '0;
    running_d = (state_d != ST_IDLE);
    step_d    = pc_d;
    if (state_d == ST_ADDR) begin
      bus_ad_d = {3'b000, cur_d.addr};
    end else if (state_d == ST_DATA) begin
      bus_sel_d = 1'b1;
      bus_ad_d  = cur_d.data;
    end
  end

  // State, program counter, current entry and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cur_q     <= '0;
      bus_sel_q <= 1'b0;
      bus_ad_q  <= '0;
      running_q <= 1'b0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cur_q     <= cur_d;
      bus_sel_q <= bus_sel_d;
      bus_ad_q  <= bus_ad_d;
      running_q <= running_d;
      step_q    <= step_d;
    end
  end

  assign bus_sel       = bus_sel_q;
  assign bus_addr_data = bus_ad_q;
  assign running       = running_q;
  assign step          = step_q;

endmodule
